lcd_ctrl_param: RTL
===================

# lcd_ctrl_param

Parametrised image-processing display controller. It loads a COLS×ROWS frame of DW-bit pixels from the image ROM and applies host commands to a movable 2×2 operation window. On request it streams the frame to the image RAM. Unlike the fixed 8×8 controller, this block adds configurable frame size and pixel width, a reload command, a median command, and repeatable write-back with a one-cycle done pulse.

## Interface
- COLS, default 8: frame width in pixels, ≥2.
- ROWS, default 8: frame height in pixels, ≥2.
- DW, default 8: pixel width in bits.
- AW, default 6: address width. Constraint: COLS*ROWS ≤ 2**AW.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command opcode.
- cmd_valid  in  1  command strobe; sampled only while busy=0.
- IROM_Q  in  DW  ROM read data; asynchronous ROM, valid in the same cycle as IROM_A.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  AW  ROM address.
- IRAM_valid  out  1  RAM write strobe.
- IRAM_A  out  AW  RAM address.
- IRAM_D  out  DW  RAM write data.
- busy  out  1  high while the block cannot accept a command.
- done  out  1  one-cycle pulse when a write-back completes.

## Operation
- N = COLS*ROWS pixels, raster order, index = y*COLS + x.
- Window origin (x,y) is the top-left pixel of the window.
  - Window pixels: P0=(x,y), P1=(x+1,y), P2=(x,y+1), P3=(x+1,y+1).
  - Origin range: x 0..COLS-2, y 0..ROWS-2.
  - Origin after reset and after reload: (COLS/2-1, ROWS/2-1), integer division.
- States: LOAD, IDLE, EXEC, WRITE.
  - LOAD→IDLE after pixel N-1 is captured.
  - IDLE→EXEC, LOAD or WRITE on an accepted command.
  - EXEC→IDLE after 1 cycle.
  - WRITE→IDLE after N cycles.
- Opcodes:
  - 0 write: stream all N pixels to RAM.
  - 1 up, 2 down, 3 left, 4 right: move the origin by 1. At the range edge the origin saturates; no wrap.
  - 5 max: P0..P3 ← max of the four pixels.
  - 6 min: P0..P3 ← min of the four pixels.
  - 7 average: P0..P3 ← floor(sum/4). Sum is computed at DW+2 bits with no overflow.
  - 8 counter-clockwise rotate: P0←P1, P1←P3, P2←P0, P3←P2.
  - 9 clockwise rotate: P0←P2, P1←P0, P2←P3, P3←P1.
  - A mirror X: P0↔P2, P1↔P3.
  - B mirror Y: P0↔P1, P2↔P3.
  - C reload: re-enter LOAD and reset the origin.
  - D median: P0..P3 ← floor((sum−max−min)/2), computed at DW+2 bits.
  - E, F: no-op. Block spends 1 EXEC cycle, no state change.
- All four window pixels update simultaneously from pre-update values.
- Pixels outside the window never change except during LOAD.

## Timing
- While reset is asserted, outputs are:
  - busy=1, IROM_rd=1, IROM_A=0
  - IRAM_valid=0, IRAM_A=0, IRAM_D=0, done=0
  - State is LOAD. Frame contents are don't-care until loaded.
- LOAD: on load cycle k (k=0..N-1), IROM_rd=1 and IROM_A=k. IROM_Q is captured into pixel k at the closing edge.
  - At the edge that captures pixel N-1: IROM_rd←0 and busy←0.
  - LOAD lasts exactly N cycles.
- Command accept: at a rising edge with busy=0 and cmd_valid=1. busy=1 from the next cycle.
  - cmd_valid while busy=1 is ignored; commands are not queued.
- EXEC commands (1–B, D–F): busy high for exactly 1 cycle. The result is visible when busy falls.
- Reload (C): busy and IROM_rd high for N cycles, same sequence as the post-reset load.
- Write (0): on write cycle i (i=0..N-1), IRAM_valid=1, IRAM_A=i, IRAM_D=pixel i.
  - At the edge after i=N-1: IRAM_valid←0 and busy←0.
  - done=1 for exactly that one cycle.
  - IRAM_A and IRAM_D hold their last values when IRAM_valid=0.
- Further commands, including a repeated write, are legal after write-back completes.
- Reset asserted mid-LOAD, EXEC or WRITE: outputs take their reset values immediately (asynchronously). The block restarts LOAD after release. A partial RAM write is not resumed.

## Test plan
- ROM pixel i = i, defaults:
  - After reset, busy stays high for 64 cycles with IROM_A 0..63.
  - Then write: 64 RAM writes with IRAM_D=IRAM_A, done pulses 1 cycle, busy falls with it.
- Defaults, origin (3,3), window pixels 27/28/35/36:
  - max → 36,36,36,36; reload, then min → 27 ×4.
  - Reload, then average → 31 ×4; reload, then median → 31 ×4.
  - Verify via write.
- Rotate/mirror at origin (3,3):
  - clockwise → P0..P3 = 35,27,36,28.
  - Then counter-clockwise restores 27,28,35,36.
  - mirror X → 35,36,27,28; mirror Y from the start → 28,27,36,35.
- Edges:
  - 5× up then max → window pixels 3,4,11,12 all become 12.
  - 10× right, 10× down then min → window 54,55,62,63 all become 54.
  - Pixels outside the window remain unchanged.
- Handshake: cmd_valid held high with an up command during busy → exactly one move. Opcode E → busy 1 cycle, frame unchanged.
- COLS=4, ROWS=2, DW=4, AW=3, ROM i=i+8:
  - Origin is (1,0).
  - average → (9+10+13+14)/4=11; window pixels 1,2,5,6 all become 11.
  - Reset asserted on write cycle 3 → IRAM_valid drops at once, and LOAD restarts after release.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// Parametrised display controller: loads a COLS x ROWS frame from ROM, applies 2x2 window ops, streams the frame to RAM.
// Load and write take N cycles, other commands 1 cycle; busy masks cmd_valid and commands are never queued.
module lcd_ctrl_param #(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int DW   = 8,
    parameter int AW   = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [AW-1:0] IRAM_A,
    output logic [DW-1:0] IRAM_D,
    output logic          busy,
    output logic          done
);
    localparam int N = COLS * ROWS;
    localparam logic [AW-1:0] LAST   = AW'(N - 1);
    localparam logic [AW-1:0] XMAX   = AW'(COLS - 2);
    localparam logic [AW-1:0] YMAX   = AW'(ROWS - 2);
    localparam logic [AW-1:0] X0     = AW'(COLS / 2 - 1);
    localparam logic [AW-1:0] Y0     = AW'(ROWS / 2 - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, x_q, y_q, last_a_q;
    logic [3:0]    op_q;
    logic [DW-1:0] last_d_q;
    logic          done_q;
    // Sized to the full address space so any AW-bit index is in range.
    logic [DW-1:0] frame_q [2**AW];

    logic [AW-1:0] i0, i1, i2, i3;
    logic [DW-1:0] p0, p1, p2, p3, n0, n1, n2, n3, mx, mn, mx01, mx23, mn01, mn23;
    logic [DW+1:0] sum, med_sum;

    assign i0 = y_q * COLS_A + x_q;
    assign i1 = i0 + 1'b1;
    assign i2 = i0 + COLS_A;
    assign i3 = i2 + 1'b1;
    assign p0 = frame_q[i0];
    assign p1 = frame_q[i1];
    assign p2 = frame_q[i2];
    assign p3 = frame_q[i3];

    assign mx01    = (p0 > p1) ? p0 : p1;
    assign mx23    = (p2 > p3) ? p2 : p3;
    assign mn01    = (p0 < p1) ? p0 : p1;
    assign mn23    = (p2 < p3) ? p2 : p3;
    assign mx      = (mx01 > mx23) ? mx01 : mx23;
    assign mn      = (mn01 < mn23) ? mn01 : mn23;
    assign sum     = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    assign med_sum = sum - {2'b00, mx} - {2'b00, mn};

    // Window result; moves and no-ops write the window back unchanged.
    always_comb begin
        n0 = p0; n1 = p1; n2 = p2; n3 = p3;
        case (op_q)
            4'h5: begin n0 = mx; n1 = mx; n2 = mx; n3 = mx; end
            4'h6: begin n0 = mn; n1 = mn; n2 = mn; n3 = mn; end
            4'h7: begin n0 = sum[DW+1:2]; n1 = sum[DW+1:2]; n2 = sum[DW+1:2]; n3 = sum[DW+1:2]; end
            4'h8: begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
            4'h9: begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
            4'hA: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
            4'hB: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
            4'hD: begin n0 = med_sum[DW:1]; n1 = med_sum[DW:1]; n2 = med_sum[DW:1]; n3 = med_sum[DW:1]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (cnt_q == LAST) state_d = S_IDLE;
            S_IDLE:  if (cmd_valid) begin
                         if (cmd == 4'h0)      state_d = S_WRITE;
                         else if (cmd == 4'hC) state_d = S_LOAD;
                         else                  state_d = S_EXEC;
                     end
            S_EXEC:  state_d = S_IDLE;
            S_WRITE: if (cnt_q == LAST) state_d = S_IDLE;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        IROM_rd    = (state_q == S_LOAD);
        IROM_A     = IROM_rd ? cnt_q : '0;
        IRAM_valid = (state_q == S_WRITE);
        IRAM_A     = IRAM_valid ? cnt_q : last_a_q;
        IRAM_D     = IRAM_valid ? frame_q[cnt_q] : last_d_q;
        done       = done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            x_q      <= X0;
            y_q      <= Y0;
            op_q     <= 4'h0;
            last_a_q <= '0;
            last_d_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_LOAD: cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                S_IDLE: if (cmd_valid) begin
                    op_q  <= cmd;
                    cnt_q <= '0;
                    if (cmd == 4'hC) begin
                        x_q <= X0;
                        y_q <= Y0;
                    end
                end
                S_EXEC: case (op_q)
                    4'h1: if (y_q != '0)   y_q <= y_q - 1'b1;
                    4'h2: if (y_q != YMAX) y_q <= y_q + 1'b1;
                    4'h3: if (x_q != '0)   x_q <= x_q - 1'b1;
                    4'h4: if (x_q != XMAX) x_q <= x_q + 1'b1;
                    default: ;
                endcase
                S_WRITE: if (cnt_q == LAST) begin
                    cnt_q    <= '0;
                    last_a_q <= cnt_q;
                    last_d_q <= frame_q[cnt_q];
                    done_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            frame_q[cnt_q] <= IROM_Q;
        end else if (state_q == S_EXEC) begin
            frame_q[i0] <= n0;
            frame_q[i1] <= n1;
            frame_q[i2] <= n2;
            frame_q[i3] <= n3;
        end
    end
endmodule
